// File: rtl/d3s_acq_buffer_mc.sv
// Multi-channel triggered acquisition buffer.
// N parallel sample streams are written into one circular RAM. Capture runs with a
// programmable pre/post-trigger depth, then freezes, and the record is read back
// through a random-access port whose index is relative to the first record sample.
module d3s_acq_buffer_mc #(
    parameter int g_num_channels = 4,
    parameter int g_data_width   = 16,
    parameter int g_size_log2    = 10
) (
    input  logic                                                        clk_sys_i,
    input  logic                                                        rst_sys_i,
    input  logic                                                        acq_start_i,
    input  logic                                                        acq_abort_i,
    input  logic [g_size_log2-1:0]                                      pre_samples_i,
    input  logic [g_size_log2:0]                                        post_samples_i,
    input  logic                                                        sw_trig_i,
    input  logic                                                        ext_trig_i,
    input  logic                                                        ext_trig_en_i,
    input  logic [g_num_channels*g_data_width-1:0]                      data_i,
    input  logic                                                        valid_i,
    output logic                                                        busy_o,
    output logic                                                        ready_o,
    output logic [g_size_log2-1:0]                                      trig_pos_o,
    output logic [g_size_log2:0]                                        rec_len_o,
    input  logic [((g_num_channels > 1) ? $clog2(g_num_channels) : 1)-1:0] rd_chan_i,
    input  logic [g_size_log2-1:0]                                      rd_addr_i,
    output logic [g_data_width-1:0]                                     rd_data_o
);

    localparam int N  = g_num_channels;
    localparam int W  = g_data_width;
    localparam int AW = g_size_log2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [AW:0] LP_DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LP_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_TRIG_WAIT,
        ST_POST,
        ST_READY
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic            r_ext_d;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_pre;
    logic [AW:0]     r_post;
    logic [AW:0]     r_cnt;
    logic [AW-1:0]   r_trig_pos;
    logic [AW:0]     r_rec_len;

    logic [N*W-1:0]  r_mem [0:(1 << AW)-1];
    logic [N*W-1:0]  r_rd_word;
    logic [CW-1:0]   r_rd_chan;
    logic [W-1:0]    r_rd_data;

    logic            w_ext_edge;
    logic            w_trig;
    logic            w_wr;
    logic            w_load;
    logic            w_cap;
    logic            w_cnt_inc;
    logic            w_busy;
    logic            w_ready;
    logic [AW:0]     w_post_lim;
    logic [AW:0]     w_post_min;
    logic [AW:0]     w_post_eff;
    logic [AW:0]     w_cnt_p1;
    logic [AW-1:0]   w_rd_phys;
    logic [W-1:0]    w_rd_sel;
    logic [W-1:0]    w_words [N];

    // Trigger qualification and post-trigger depth clamp for the config being latched.
    always_comb begin
        w_ext_edge = ext_trig_i & ~r_ext_d;
        w_trig     = sw_trig_i | (ext_trig_en_i & w_ext_edge);
        w_post_lim = LP_DEPTH - {1'b0, pre_samples_i};
        w_post_min = (post_samples_i < w_post_lim) ? post_samples_i : w_post_lim;
        w_post_eff = (w_post_min == '0) ? LP_ONE : w_post_min;
        w_cnt_p1   = r_cnt + LP_ONE;
        w_rd_phys  = r_trig_pos - r_pre + rd_addr_i;
    end

    // Next-state, write enable and counter control; abort outranks start.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_load      = 1'b0;
        w_cap       = 1'b0;
        w_cnt_inc   = 1'b0;
        w_busy      = 1'b0;
        w_ready     = 1'b0;

        case (r_state)
            ST_PRE, ST_ARMED, ST_TRIG_WAIT, ST_POST: w_busy = 1'b1;
            ST_READY:                                w_ready = 1'b1;
            default:                                 ;
        endcase

        if (acq_abort_i) begin
            w_state_nxt = ST_IDLE;
        end else if (acq_start_i) begin
            w_load      = 1'b1;
            w_state_nxt = (pre_samples_i == '0) ? ST_ARMED : ST_PRE;
        end else begin
            case (r_state)
                ST_PRE: begin
                    if (valid_i) begin
                        w_wr      = 1'b1;
                        w_cnt_inc = 1'b1;
                        if (w_cnt_p1 == {1'b0, r_pre}) w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (valid_i) w_wr = 1'b1;
                    if (w_trig) begin
                        if (valid_i) begin
                            w_cap       = 1'b1;
                            w_state_nxt = (r_post == LP_ONE) ? ST_READY : ST_POST;
                        end else begin
                            w_state_nxt = ST_TRIG_WAIT;
                        end
                    end
                end
                ST_TRIG_WAIT: begin
                    if (valid_i) begin
                        w_wr        = 1'b1;
                        w_cap       = 1'b1;
                        w_state_nxt = (r_post == LP_ONE) ? ST_READY : ST_POST;
                    end
                end
                ST_POST: begin
                    if (valid_i) begin
                        w_wr      = 1'b1;
                        w_cnt_inc = 1'b1;
                        if (w_cnt_p1 == r_post) w_state_nxt = ST_READY;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Write pointer, latched config, fill/post counter and trigger address.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_ext_d    <= 1'b0;
            r_wptr     <= '0;
            r_pre      <= '0;
            r_post     <= '0;
            r_cnt      <= '0;
            r_trig_pos <= '0;
            r_rec_len  <= '0;
        end else begin
            r_ext_d <= ext_trig_i;
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_load) begin
                r_pre     <= pre_samples_i;
                r_post    <= w_post_eff;
                r_rec_len <= {1'b0, pre_samples_i} + w_post_eff;
                r_cnt     <= '0;
            end else if (w_cap) begin
                r_trig_pos <= r_wptr;
                r_cnt      <= LP_ONE;
            end else if (w_cnt_inc) begin
                r_cnt <= w_cnt_p1;
            end
        end
    end

    // Sample RAM write port: all channels stored side by side at one address.
    always_ff @(posedge clk_sys_i) begin
        if (w_wr) r_mem[r_wptr] <= data_i;
    end

    // Sample RAM read port; channel select travels alongside the read word.
    always_ff @(posedge clk_sys_i) begin
        r_rd_word <= r_mem[w_rd_phys];
        r_rd_chan <= rd_chan_i;
    end

    for (genvar k = 0; k < N; k++) begin : g_words
        assign w_words[k] = r_rd_word[k*W +: W];
    end

    // Channel mux; out-of-range channel numbers read as zero.
    always_comb begin
        w_rd_sel = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (r_rd_chan == CW'(k)) w_rd_sel = w_words[k];
        end
    end

    // Registered readout, second stage of the read pipeline.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) r_rd_data <= '0;
        else           r_rd_data <= w_rd_sel;
    end

    assign busy_o     = w_busy;
    assign ready_o    = w_ready;
    assign trig_pos_o = r_trig_pos;
    assign rec_len_o  = r_rec_len;
    assign rd_data_o  = r_rd_data;

endmodule
